// File: rtl/lsu_unit.sv
// lsu_unit: single-outstanding load/store unit between execute and the data-memory port.
// Define LSU_TIMEOUT_EN to fault accesses whose ack never arrives within TIMEOUT_CYCLES.
module lsu_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_req;
    logic [31:0] wdata_req;
    logic [31:0] lane_data;
    logic [31:0] load_fmt;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Decode of the incoming request: legality, alignment, lane enables and replicated data.
    always_comb begin
        illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_req    = 4'b0001 << addr[1:0];
                wdata_req = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_req    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_req = {2{store_data[15:0]}};
            end
            default: begin
                be_req    = 4'b1111;
                wdata_req = store_data;
            end
        endcase
    end

    always_comb begin
        lane_data = mem_rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_fmt = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_fmt = {24'b0, lane_data[7:0]};
            3'b101:  load_fmt = {16'b0, lane_data[15:0]};
            default: load_fmt = lane_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        done_d       = 1'b0;
        fault_d      = 1'b0;
        fault_code_d = 2'b00;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        rd_data_d    = rd_data_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d    = funct3;
                    lane_d      = addr[1:0];
                    req_ready_d = 1'b0;
                    if (illegal || misaligned) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        fault_d      = 1'b1;
                        fault_code_d = illegal ? 2'b10 : 2'b01;
                    end else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = be_req;
                        mem_wdata_d = wdata_req;
`ifdef LSU_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                // An ack on the terminal-count edge still completes the access normally.
                if (mem_ack) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rd_data_d = load_fmt;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = DONE;
                    done_d       = 1'b1;
                    fault_d      = 1'b1;
                    fault_code_d = 2'b11;
                    mem_req_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mem_req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            rd_data_q    <= '0;
            funct3_q     <= '0;
            lane_q       <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_data_q    <= rd_data_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign rd_data    = rd_data_q;

endmodule
